// File: rtl/fp32_serial_multiplier.sv
// fp32_serial_multiplier: IEEE-754 binary32 multiplier fed from one serial
// operand bus. A fixed five-step sequence (LOAD_A, GAP, LOAD_B, CALC, DONE)
// captures operand A, skips one changeover cycle, captures operand B, then
// registers the product and raises ready.
// Subnormal inputs and results are flushed to zero. Any NaN, or Inf times
// zero, returns the canonical quiet NaN 0x7FC00000.
// Rounding is truncation by default. Defining FPMUL_ROUND_NEAREST_EN
// selects round-to-nearest-ties-to-even instead.
module fp32_serial_multiplier (
  input  logic        clock,
  input  logic        nreset,
  input  logic [31:0] a,
  output logic [31:0] product,
  output logic        ready
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    GAP    = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;

  // Operand fields
  logic       sign_a, sign_b, sign_r;
  logic [7:0] exp_a, exp_b;
  logic [22:0] frac_a, frac_b;

  // Operand classification
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  // Datapath intermediates
  logic [47:0]       mant_prod;
  logic signed [9:0] exp_raw;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;
  logic [23:0]       mant_norm;
  logic [22:0]       frac_fin;

  assign sign_a = op_a[31];
  assign sign_b = op_b[31];
  assign exp_a  = op_a[30:23];
  assign exp_b  = op_b[30:23];
  assign frac_a = op_a[22:0];
  assign frac_b = op_b[22:0];
  assign sign_r = sign_a ^ sign_b;

  assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
  // Subnormals count as zero because inputs are flushed to zero.
  assign zero_a = (exp_a == 8'h00);
  assign zero_b = (exp_b == 8'h00);

  assign mant_prod = {1'b1, frac_a} * {1'b1, frac_b};
  assign exp_raw   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

  // Normalise the 48-bit mantissa product so the leading one is bit 23 of mant_norm.
  always_comb begin
    if (mant_prod[47]) begin
      mant_norm = mant_prod[47:24];
      exp_norm  = exp_raw + 10'sd1;
    end else begin
      mant_norm = mant_prod[46:23];
      exp_norm  = exp_raw;
    end
  end

`ifdef FPMUL_ROUND_NEAREST_EN
  logic        guard_bit, round_bit, sticky_bit, round_up;
  logic [24:0] mant_rnd;

  // Round to nearest, ties to even. Bit 0 dropped by the normalising shift
  // still counts toward sticky, so the tie detection is exact.
  always_comb begin
    if (mant_prod[47]) begin
      guard_bit  = mant_prod[23];
      round_bit  = mant_prod[22];
      sticky_bit = |mant_prod[21:0];
    end else begin
      guard_bit  = mant_prod[22];
      round_bit  = mant_prod[21];
      sticky_bit = |mant_prod[20:0];
    end
    round_up = guard_bit & (round_bit | sticky_bit | mant_norm[0]);
    mant_rnd = {1'b0, mant_norm} + {24'd0, round_up};
    if (mant_rnd[24]) begin
      frac_fin = mant_rnd[23:1];
      exp_fin  = exp_norm + 10'sd1;
    end else begin
      frac_fin = mant_rnd[22:0];
      exp_fin  = exp_norm;
    end
  end
`else
  // Truncation: the low product bits only feed rounding, so they are discarded here.
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, mant_prod[22:0]};
  assign frac_fin = mant_norm[22:0];
  assign exp_fin  = exp_norm;
`endif

  // Apply the special cases in priority order, then range-check the exponent.
  always_comb begin
    if (nan_a || nan_b || ((inf_a || inf_b) && (zero_a || zero_b))) begin
      result = 32'h7FC00000;
    end else if (inf_a || inf_b) begin
      result = {sign_r, 8'hFF, 23'd0};
    end else if (zero_a || zero_b) begin
      result = {sign_r, 31'd0};
    end else if (exp_fin >= 10'sd255) begin
      result = {sign_r, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      result = {sign_r, 31'd0};
    end else begin
      result = {sign_r, exp_fin[7:0], frac_fin};
    end
  end

  // Fixed-timing sequencer: operand capture, product register and ready flag.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state   <= LOAD_A;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      product <= 32'd0;
      ready   <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          op_a  <= a;
          ready <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          state <= LOAD_B;
        end
        LOAD_B: begin
          op_b  <= a;
          state <= CALC;
        end
        CALC: begin
          product <= result;
          ready   <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          state <= LOAD_A;
        end
        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_serial_multiplier.sv
// Self-checking bench for fp32_serial_multiplier. It runs directed and
// random operand pairs against an exact integer reference model, and it
// also checks reset behaviour and ready timing.
module tb_fp32_serial_multiplier;

  logic        clock;
  logic        nreset;
  logic [31:0] a;
  logic [31:0] product;
  logic        ready;

  int n_tests;
  int n_fail;
  logic [31:0] prev_product;

  fp32_serial_multiplier dut (
    .clock   (clock),
    .nreset  (nreset),
    .a       (a),
    .product (product),
    .ready   (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: the exact product is formed as an integer. It is
  // scaled to 24 significant bits, and the discarded remainder decides
  // the rounding.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    int     ex, ey, e, sh;
    longint mx, my, m, q, rem;
    bit     x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    x_nan  = (ex == 255) && (x[22:0] != 0);
    y_nan  = (ey == 255) && (y[22:0] != 0);
    x_inf  = (ex == 255) && (x[22:0] == 0);
    y_inf  = (ey == 255) && (y[22:0] == 0);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    if (x_nan || y_nan || ((x_inf || y_inf) && (x_zero || y_zero))) return 32'h7FC00000;
    if (x_inf || y_inf) return {s, 8'hFF, 23'd0};
    if (x_zero || y_zero) return {s, 31'd0};
    mx = 64'd8388608 + longint'(x[22:0]);
    my = 64'd8388608 + longint'(y[22:0]);
    m  = mx * my;
    e  = ex + ey - 127;
    sh = 23;
    if (m >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q   = m >> sh;
    rem = m - (q << sh);
`ifdef FPMUL_ROUND_NEAREST_EN
    if (rem > (64'd1 << (sh - 1)) || (rem == (64'd1 << (sh - 1)) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
`else
    if (rem < 0) q = 0;
`endif
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       r[30:23] = 8'd0;
      1:       r[30:23] = 8'hFF;
      2:       begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      3:       r[30:23] = 8'($urandom_range(190, 254));
      4:       r[30:23] = 8'($urandom_range(1, 64));
      5:       r = r;
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // Drives one operand pair through the five-state sequence, with junk
  // on the bus in the slots the design ignores. It starts just before
  // the LOAD_A edge and ends just before the next LOAD_A edge.
  task automatic do_pair(input logic [31:0] opa, input logic [31:0] opb, input logic [31:0] exp);
    a = opa;
    @(posedge clock); #1;
    check("rdy_after_load_a", {31'd0, ready}, 32'd0);
    check("hold_after_load_a", product, prev_product);
    @(negedge clock); a = $urandom;
    @(posedge clock); #1;
    check("rdy_after_gap", {31'd0, ready}, 32'd0);
    @(negedge clock); a = opb;
    @(posedge clock); #1;
    check("rdy_after_load_b", {31'd0, ready}, 32'd0);
    check("hold_after_load_b", product, prev_product);
    @(negedge clock); a = $urandom;
    @(posedge clock); #1;
    check("rdy_after_calc", {31'd0, ready}, 32'd1);
    check("product", product, exp);
    @(negedge clock); a = $urandom;
    @(posedge clock); #1;
    check("rdy_after_done", {31'd0, ready}, 32'd1);
    check("hold_after_done", product, exp);
    $display("[TB] pair %08h * %08h -> %08h (expected %08h) ready=%0b", opa, opb, product, exp, ready);
    prev_product = exp;
    @(negedge clock);
  endtask

  logic [31:0] dir_a [8];
  logic [31:0] dir_b [8];

  initial begin
    logic [31:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;
    prev_product = 32'd0;
    a = 32'd0;
    nreset = 1'b0;

    dir_a[0] = 32'h3F333333; dir_b[0] = 32'h3DCCCCCD;
    dir_a[1] = 32'h469C41CD; dir_b[1] = 32'h461C4066;
    dir_a[2] = 32'h40000000; dir_b[2] = 32'hC0400000;
    dir_a[3] = 32'h7F800000; dir_b[3] = 32'h00000000;
    dir_a[4] = 32'h7F000000; dir_b[4] = 32'h7F000000;
    dir_a[5] = 32'h00800000; dir_b[5] = 32'h00800000;
    dir_a[6] = 32'h7FC12345; dir_b[6] = 32'h3F800000;
    dir_a[7] = 32'hFF800000; dir_b[7] = 32'h40400000;

    repeat (3) @(posedge clock);
    #1;
    check("reset_product", product, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);

    @(negedge clock);
    nreset = 1'b1;

    // Directed cases. Constants are written out where they are given
    // as known-good products.
`ifdef FPMUL_ROUND_NEAREST_EN
    do_pair(dir_a[0], dir_b[0], 32'h3D8F5C29);
`else
    do_pair(dir_a[0], dir_b[0], 32'h3D8F5C28);
`endif
    do_pair(dir_a[1], dir_b[1], 32'h4D3EBECF);
    do_pair(dir_a[2], dir_b[2], 32'hC0C00000);
    do_pair(dir_a[3], dir_b[3], 32'h7FC00000);
    do_pair(dir_a[4], dir_b[4], 32'h7F800000);
    do_pair(dir_a[5], dir_b[5], 32'h00000000);
    do_pair(dir_a[6], dir_b[6], 32'h7FC00000);
    do_pair(dir_a[7], dir_b[7], 32'hFF800000);

    // Abort in GAP: reset clears product and ready without waiting for a clock edge.
    a = 32'h40400000;
    @(posedge clock);
    @(negedge clock);
    nreset = 1'b0;
    #1;
    check("abort_product", product, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    prev_product = 32'd0;
    do_pair(32'h40000000, 32'h40A00000, 32'h41200000);

    for (int i = 0; i < 200; i++) begin
      ra = rand_op();
      rb = rand_op();
      do_pair(ra, rb, ref_mul(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
